// File: rtl/core_seq.sv
// rtl/core_seq.sv - per-kij conv schedule sequencer between host and core
//
// Steps the core through, for every output tile and every kernel position:
// clear -> weight feed to L0 -> activation feed -> PSUM drain, then after the
// last kij a ReLU settle, readout start, and readout window.
//
// Optional feature macro: SEQ_PAUSE_EN (pause input freezes WLOAD/ALOAD/DRAIN/RELU).
//
// Ports:
//   clk            in   clock, rising edge
//   reset          in   asynchronous active-low reset
//   start          in   run request, sampled only in IDLE
//   pause          in   hold request (effective only with SEQ_PAUSE_EN)
//   busy           out  high while a run is in progress (not in DONE)
//   done           out  1-cycle completion pulse
//   core_rst       out  active-high clear to the core
//   inst_w         out  01 weight feed, 10 activation feed, 00 idle
//   CEN_xmem       out  X_MEM chip enable, active-low
//   WEN_xmem       out  X_MEM write enable, active-low, always 1
//   A_xmem         out  X_MEM address
//   kij            out  current kernel index
//   otile          out  current output tile
//   readout_start  out  1-cycle readout kick to the core
//   rd_valid       out  high while the readout bus carries data
`timescale 1ns/1ps
module core_seq #(
    parameter int ADDR_BW   = 11,
    parameter int COL       = 8,
    parameter int LEN_NIJ   = 36,
    parameter int LEN_KIJ   = 9,
    parameter int LEN_ONIJ  = 16,
    parameter int N_OTILE   = 1,
    parameter int W_BASE    = 1024,
    parameter int CLR_CYC   = 10,
    parameter int DRAIN_CYC = 30,
    parameter int RELU_CYC  = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               pause,
    output logic               busy,
    output logic               done,
    output logic               core_rst,
    output logic [1:0]         inst_w,
    output logic               CEN_xmem,
    output logic               WEN_xmem,
    output logic [ADDR_BW-1:0] A_xmem,
    output logic [3:0]         kij,
    output logic [7:0]         otile,
    output logic               readout_start,
    output logic               rd_valid
);

    localparam int M0     = (CLR_CYC > COL) ? CLR_CYC : COL;
    localparam int M1     = (M0 > LEN_NIJ) ? M0 : LEN_NIJ;
    localparam int M2     = (M1 > DRAIN_CYC + 1) ? M1 : DRAIN_CYC + 1;
    localparam int M3     = (M2 > RELU_CYC) ? M2 : RELU_CYC;
    localparam int MAXLEN = (M3 > LEN_ONIJ) ? M3 : LEN_ONIJ;
    localparam int CW     = $clog2(MAXLEN) + 1;

    localparam logic [CW-1:0] L_CLR   = CW'(CLR_CYC - 1);
    localparam logic [CW-1:0] L_WLOAD = CW'(COL - 1);
    localparam logic [CW-1:0] L_ALOAD = CW'(LEN_NIJ - 1);
    localparam logic [CW-1:0] L_DRAIN = CW'(DRAIN_CYC);
    localparam logic [CW-1:0] L_RELU  = CW'(RELU_CYC - 1);
    localparam logic [CW-1:0] L_READ  = CW'(LEN_ONIJ - 1);
    localparam logic [3:0]    KIJ_LAST = 4'(LEN_KIJ - 1);
    localparam logic [7:0]    OT_LAST  = 8'(N_OTILE - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CLR, S_WLOAD, S_WGAP, S_ALOAD, S_DRAIN,
        S_RELU, S_RSTART, S_RWAIT, S_READ, S_DONE
    } state_t;

    state_t          r_state, w_state_n;
    logic [CW-1:0]   r_cnt, w_cnt_n, w_last_cnt;
    logic [3:0]      w_kij_n;
    logic [7:0]      w_otile_n;
    // r_hold marks the current cycle as frozen: the phase counter must not
    // advance past an access that was suppressed.
    logic            r_hold, w_hold_n;
    logic            w_last;
    logic [1:0]      w_inst_n;
    logic            w_cen_n;
    logic [ADDR_BW-1:0] w_addr_n;

    function automatic logic is_frz(input state_t s);
        return (s == S_WLOAD) || (s == S_ALOAD) || (s == S_DRAIN) || (s == S_RELU);
    endfunction

    always_comb begin
        w_last_cnt = '0;
        case (r_state)
            S_CLR:   w_last_cnt = L_CLR;
            S_WLOAD: w_last_cnt = L_WLOAD;
            S_ALOAD: w_last_cnt = L_ALOAD;
            S_DRAIN: w_last_cnt = L_DRAIN;
            S_RELU:  w_last_cnt = L_RELU;
            S_READ:  w_last_cnt = L_READ;
            default: w_last_cnt = '0;
        endcase
        w_last = (r_cnt == w_last_cnt);
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_kij_n   = kij;
        w_otile_n = otile;
        case (r_state)
            S_IDLE: begin
                w_cnt_n = '0;
                if (start) begin
                    w_state_n = S_CLR;
                    w_kij_n   = '0;
                    w_otile_n = '0;
                end
            end
            S_WGAP: begin
                w_state_n = S_ALOAD;
                w_cnt_n   = '0;
            end
            S_RSTART: w_state_n = S_RWAIT;
            S_RWAIT: begin
                w_state_n = S_READ;
                w_cnt_n   = '0;
            end
            S_DONE: w_state_n = S_IDLE;
            default: begin
                if (!r_hold) begin
                    if (w_last) begin
                        w_cnt_n = '0;
                        case (r_state)
                            S_CLR:   w_state_n = S_WLOAD;
                            S_WLOAD: w_state_n = S_WGAP;
                            S_ALOAD: w_state_n = S_DRAIN;
                            S_DRAIN: begin
                                if (kij < KIJ_LAST) begin
                                    w_kij_n   = kij + 4'd1;
                                    w_state_n = S_CLR;
                                end else begin
                                    w_state_n = S_RELU;
                                end
                            end
                            S_RELU:  w_state_n = S_RSTART;
                            S_READ: begin
                                if (otile < OT_LAST) begin
                                    w_otile_n = otile + 8'd1;
                                    w_kij_n   = '0;
                                    w_state_n = S_CLR;
                                end else begin
                                    w_state_n = S_DONE;
                                end
                            end
                            default: w_state_n = S_IDLE;
                        endcase
                    end else begin
                        w_cnt_n = r_cnt + 1'b1;
                    end
                end
            end
        endcase
    end

    // Outputs are registered from the next-state values so each output
    // cycle lines up with the state it belongs to.
    always_comb begin
`ifdef SEQ_PAUSE_EN
        w_hold_n = pause && is_frz(r_state) && is_frz(w_state_n);
`else
        // pause has no effect in this build
        w_hold_n = pause & 1'b0;
`endif
        w_inst_n = 2'b00;
        w_cen_n  = 1'b1;
        w_addr_n = '0;
        if (w_state_n == S_WLOAD) begin
            w_addr_n = ADDR_BW'(W_BASE + (int'(w_otile_n) * LEN_KIJ + int'(w_kij_n)) * COL
                                + int'(w_cnt_n));
            if (!w_hold_n) begin
                w_inst_n = 2'b01;
                w_cen_n  = 1'b0;
            end
        end else if (w_state_n == S_ALOAD) begin
            w_addr_n = ADDR_BW'(w_cnt_n);
            if (!w_hold_n) begin
                w_inst_n = 2'b10;
                w_cen_n  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_hold        <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            core_rst      <= 1'b0;
            inst_w        <= 2'b00;
            CEN_xmem      <= 1'b1;
            WEN_xmem      <= 1'b1;
            A_xmem        <= '0;
            kij           <= '0;
            otile         <= '0;
            readout_start <= 1'b0;
            rd_valid      <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_cnt         <= w_cnt_n;
            r_hold        <= w_hold_n;
            busy          <= (w_state_n != S_IDLE) && (w_state_n != S_DONE);
            done          <= (w_state_n == S_DONE);
            core_rst      <= (w_state_n == S_CLR);
            inst_w        <= w_inst_n;
            CEN_xmem      <= w_cen_n;
            WEN_xmem      <= 1'b1;
            A_xmem        <= w_addr_n;
            kij           <= w_kij_n;
            otile         <= w_otile_n;
            readout_start <= (w_state_n == S_RSTART);
            rd_valid      <= (w_state_n == S_READ);
        end
    end

endmodule
